// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between the CPU and the program loader.
// Each access is sequenced over WAIT_CYCLES cycles and finishes with a one-cycle ack to its owner.
module mem_access_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stop,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             last_grant;
    logic             pick_l;
    logic             start;
    logic             done;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        pick_l     = l_req && (!c_req || !last_grant);
        start      = (state == IDLE) && !stop && (c_req || l_req);
        done       = (state == ACCESS) && (cnt == '0);
        busy       = (state != IDLE);
        mem_re     = (state == ACCESS) && !we_q;
        mem_we     = (state == ACCESS) && we_q && (cnt == CNT_LOAD);
        c_ack      = (state == RESP) && !grant;
        l_ack      = (state == RESP) && grant;

        case (state)
            IDLE:    if (start) state_next = ACCESS;
            ACCESS:  if (done)  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last_grant resets to the loader so the CPU wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_rdata    <= '0;
            l_rdata    <= '0;
        end else if (start) begin
            grant      <= pick_l;
            last_grant <= pick_l;
            cnt        <= CNT_LOAD;
            if (pick_l) begin
                we_q      <= l_we;
                mem_addr  <= l_addr;
                mem_wdata <= l_wdata;
            end else begin
                we_q      <= c_we;
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
            end
        end else if (state == ACCESS) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done && !we_q) begin
                if (grant) begin
                    l_rdata <= mem_rdata;
                end else begin
                    c_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: table of single transactions plus sequences for arbitration,
// stop, wait states and mid-transaction reset; completions are matched against a scoreboard.
module tb_mem_access_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        stop;
    logic        c_req, c_we, l_req, l_we;
    logic [8:0]  c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;

    logic        c_ack, l_ack, mem_re, mem_we, busy, grant;
    logic [31:0] c_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [8:0]  mem_addr;

    logic        c_ack3, l_ack3, mem_re3, mem_we3, busy3, grant3;
    logic [31:0] c_rdata3, l_rdata3, mem_wdata3, mem_rdata3;
    logic [8:0]  mem_addr3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic        sb_on;
    logic [31:0] exp_c, exp_l;

    always #5 clock = ~clock;

    function automatic logic [31:0] ram_init(input logic [8:0] a);
        return (a == 9'h005) ? 32'h1234_5678 : {16'hC0DE, 7'd0, a};
    endfunction

    logic [31:0]  ram1 [512];
    logic [511:0] wr1 = '0;
    always @(posedge clock) begin
        if (mem_we) begin
            ram1[mem_addr] <= mem_wdata;
            wr1[mem_addr]  <= 1'b1;
        end
    end
    assign mem_rdata = wr1[mem_addr] ? ram1[mem_addr] : ram_init(mem_addr);

    logic [31:0]  ram3 [512];
    logic [511:0] wr3 = '0;
    always @(posedge clock) begin
        if (mem_we3) begin
            ram3[mem_addr3] <= mem_wdata3;
            wr3[mem_addr3]  <= 1'b1;
        end
    end
    assign mem_rdata3 = wr3[mem_addr3] ? ram3[mem_addr3] : ram_init(mem_addr3);

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .stop(stop),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .stop(stop),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack3), .c_rdata(c_rdata3),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack3), .l_rdata(l_rdata3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3), .mem_we(mem_we3),
        .mem_rdata(mem_rdata3), .busy(busy3), .grant(grant3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        check("sb_not_empty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_grant", 64'(grant), 64'(e.port));
            check("ack_port", 64'(l_ack), 64'(e.port));
            check("ack_single", 64'(c_ack & l_ack), 64'(0));
            if (!e.we) check("ack_rdata", 64'(e.port ? l_rdata : c_rdata), 64'(e.rdata));
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; completions feed the scoreboard.
    task automatic step();
        @(posedge clock);
        #1;
        if (sb_on && (c_ack || l_ack)) sb_pop();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        c_req = !v.port;  l_req = v.port;
        c_we = v.we;      l_we = v.we;
        c_addr = v.addr;  l_addr = v.addr;
        c_wdata = v.wdata; l_wdata = v.wdata;
        sb.push_back('{v.port, v.we, v.exp_rdata});
        step();
        check($sformatf("v%0d_mem_addr", idx), 64'(mem_addr), 64'(v.addr));
        check($sformatf("v%0d_mem_re", idx), 64'(mem_re), 64'(!v.we));
        check($sformatf("v%0d_mem_we", idx), 64'(mem_we), 64'(v.we));
        check($sformatf("v%0d_busy", idx), 64'(busy), 64'(1));
        if (v.we) check($sformatf("v%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.wdata));
        step();
        check($sformatf("v%0d_c_ack", idx), 64'(c_ack), 64'(!v.port));
        check($sformatf("v%0d_l_ack", idx), 64'(l_ack), 64'(v.port));
        if (!v.we) begin
            if (v.port) exp_l = v.exp_rdata;
            else        exp_c = v.exp_rdata;
        end
        check($sformatf("v%0d_c_rdata", idx), 64'(c_rdata), 64'(exp_c));
        check($sformatf("v%0d_l_rdata", idx), 64'(l_rdata), 64'(exp_l));
        c_req = 1'b0;
        l_req = 1'b0;
        step();
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'(0));
        check($sformatf("v%0d_idle_ack", idx), 64'(c_ack | l_ack), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   we_n, re_n, ack_n, ack_at, cack_n, lat;
        logic got;

        vecs[0] = '{1'b0, 1'b0, 9'h005, 32'h0000_0000, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 9'h010, 32'hA5A5_0001, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 32'hA5A5_0001};
        vecs[3] = '{1'b1, 1'b1, 9'h1FF, 32'h5A5A_00FF, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 9'h1FF, 32'h0000_0000, 32'h5A5A_00FF};
        vecs[5] = '{1'b0, 1'b0, 9'h000, 32'h0000_0000, 32'hC0DE_0000};
        vecs[6] = '{1'b1, 1'b1, 9'h005, 32'h0BAD_F00D, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b0, 9'h005, 32'h0000_0000, 32'h0BAD_F00D};
        vecs[8] = '{1'b0, 1'b0, 9'h123, 32'h0000_0000, 32'hC0DE_0123};

        reset = 1'b0; stop = 1'b0; sb_on = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        exp_c = '0; exp_l = '0;

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_c_ack", 64'(c_ack), 64'(0));
        check("rst_l_ack", 64'(l_ack), 64'(0));
        check("rst_c_rdata", 64'(c_rdata), 64'(0));
        check("rst_l_rdata", 64'(l_rdata), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_re", 64'(mem_re), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy3", 64'(busy3), 64'(0));
        #8;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_no_req_busy", 64'(busy), 64'(0));
        end

        // Single transactions, one port at a time
        for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

        // Loader write with three wait states on the second instance
        sb_on = 1'b0;
        do_reset();
        l_req = 1'b1; l_we = 1'b1; l_addr = 9'h00A; l_wdata = 32'hDEAD_BEEF;
        we_n = 0; re_n = 0; ack_n = 0; ack_at = 0; cack_n = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                check("w3_grant", 64'(grant3), 64'(1));
                check("w3_busy", 64'(busy3), 64'(1));
            end
            if (i == 3) begin
                check("w3_addr_held", 64'(mem_addr3), 64'(9'h00A));
                check("w3_wdata_held", 64'(mem_wdata3), 64'(32'hDEAD_BEEF));
            end
            if (mem_we3) begin
                we_n++;
                check("w3_we_addr", 64'(mem_addr3), 64'(9'h00A));
                check("w3_we_wdata", 64'(mem_wdata3), 64'(32'hDEAD_BEEF));
            end
            if (mem_re3) re_n++;
            if (c_ack3) cack_n++;
            if (l_ack3) begin
                ack_n++;
                ack_at = i;
                l_req = 1'b0;
            end
        end
        check("w3_we_cycles", 64'(we_n), 64'(1));
        check("w3_re_cycles", 64'(re_n), 64'(0));
        check("w3_ack_count", 64'(ack_n), 64'(1));
        check("w3_ack_cycle", 64'(ack_at), 64'(4));
        check("w3_c_ack_count", 64'(cack_n), 64'(0));
        check("w3_l_rdata", 64'(l_rdata3), 64'(0));
        check("w3_busy_end", 64'(busy3), 64'(0));
        l_we = 1'b0;
        do_reset();
        sb_on = 1'b1;

        // Both requesters held: CPU, loader, CPU, loader
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020;
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'h021;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{1'b0, 1'b0, 32'hC0DE_0020});
            else            sb.push_back('{1'b1, 1'b0, 32'hC0DE_0021});
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("rr_c_ack_%0d", i), 64'(c_ack), 64'(i == 2 || i == 8));
            check($sformatf("rr_l_ack_%0d", i), 64'(l_ack), 64'(i == 5 || i == 11));
            check($sformatf("rr_busy_%0d", i), 64'(busy), 64'(i % 3 != 0));
            if (i == 11) begin
                c_req = 1'b0;
                l_req = 1'b0;
            end
        end

        // stop blocks only the grant decision
        stop = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
        sb.push_back('{1'b0, 1'b0, 32'hC0DE_0030});
        for (int i = 0; i < 5; i++) begin
            step();
            check("stop_busy", 64'(busy), 64'(0));
        end
        stop = 1'b0;
        step();
        check("stop_rel_busy", 64'(busy), 64'(1));
        check("stop_rel_re", 64'(mem_re), 64'(1));
        check("stop_rel_addr", 64'(mem_addr), 64'(9'h030));
        stop = 1'b1;
        step();
        check("stop_mid_c_ack", 64'(c_ack), 64'(1));
        c_req = 1'b0;
        stop = 1'b0;
        step();
        check("stop_end_busy", 64'(busy), 64'(0));

        // Reset during a read access abandons it; the held request is re-granted
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h040;
        step();
        check("rr6_access_re", 64'(mem_re), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("abort_mem_re", 64'(mem_re), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_c_ack", 64'(c_ack), 64'(0));
        check("abort_c_rdata", 64'(c_rdata), 64'(0));
        #4;
        reset = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'hC0DE_0040});
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6 && !got; i++) begin
            step();
            if (c_ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("regrant_ack_seen", 64'(got), 64'(1));
        check("regrant_latency", 64'(lat), 64'(2));
        c_req = 1'b0;
        step();
        check("regrant_end_busy", 64'(busy), 64'(0));

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
